// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStartBit,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // 50 MHz system clock at 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       has_done
);

    localparam bit   USE_PARITY = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        stopcnt_q, stopcnt_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        tick;

    assign accept = (state_q == StIdle) && start;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .enable(state_q != StIdle),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        par_d     = par_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = data_in;
                    bitcnt_d  = '0;
                    stopcnt_d = 1'b0;
                    par_d     = (PARITY == PAR_ODD) ? ~^data_in : ^data_in;
                    state_d   = StStartBit;
                end
            end
            StStartBit: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = USE_PARITY ? StParity : StStop;
                end
            end
            StParity: begin
                if (tick) state_d = StStop;
            end
            StStop: begin
                if (tick) begin
                    if (stopcnt_q == LAST_STOP) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        stopcnt_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        unique case (state_d)
            StStartBit: tx_d = 1'b0;
            StData:     tx_d = shift_d[0];
            StParity:   tx_d = par_d;
            default:    tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign has_done = done_q;

endmodule
